muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer for the MIPS core's Execute stage.
- Accepts MULT/MULTU/DIV/DIVU from the E stage and stalls F/D/E while it computes over 32 cycles.
- Delivers WriteLoHiE and loHi_dataE so the E/M register carries them with the instruction, through the M/W register to the Lo/Hi write port.

Parameters:
- DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
- CLK  input  1  rising-edge clock
- RESET  input  1  asynchronous, active-high reset
- StartE  input  1  valid mult/div instruction present in E
- OpE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcAE  input  DATA_W  rs operand (multiplicand/dividend)
- SrcBE  input  DATA_W  rt operand (multiplier/divisor)
- KillE  input  1  flush of E-stage instruction; aborts operation
- StallMD  output  1  hold PC, F/D and D/E registers
- WriteLoHiE  output  1  Lo/Hi write enable to E/M register
- loHi_dataE  output  2*DATA_W  {Hi, Lo}; Hi in bits 63:32
- DivZeroE  output  1  divide-by-zero flag, qualified by WriteLoHiE
- BusyMD  output  1  state != IDLE

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE, counter 0, operand and accumulator registers 0. All outputs read 0 while RESET is high and immediately after it deasserts.
- States: IDLE, CALC, FIX, DONE.
- Cycle n is the cycle that ends at edge n. The start cycle is cycle 0.
- IDLE:
  - StartE=1 and KillE=0 at edge 0: latch OpE. Latch |SrcAE| and |SrcBE| for signed ops, raw values for unsigned ops. Record sign flags. Counter=0. Go to CALC.
- CALC (cycles 1..32): one iteration per edge; counter increments. At edge 32 (counter==DATA_W-1) go to FIX.
  - Multiply: shift-add. {acc,mplr} >> 1 with conditional add of the multiplicand into the upper half.
  - Divide: restoring. Shift {rem,quo} left 1. Subtract the divisor if rem>=divisor and set the quotient LSB.
- FIX (cycle 33): apply sign correction and register the result. Go to DONE at edge 33.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ. The remainder takes the dividend's sign.
- DONE (cycle 34): WriteLoHiE=1 and loHi_dataE valid. Go to IDLE at edge 34.
- Results:
  - Multiply: Hi=product[63:32], Lo=product[31:0].
  - Divide: Lo=quotient, Hi=remainder.
  - Arithmetic is modulo 2^DATA_W. Signed 0x80000000/0xFFFFFFFF gives Lo=0x80000000, Hi=0.
- Divide by zero (SrcBE==0, DIV or DIVU):
  - Full latency still applies.
  - Lo=0xFFFFFFFF and Hi=raw SrcAE, with no sign fix.
  - DivZeroE=1 in the DONE cycle.
- StallMD = (IDLE & StartE & ~KillE) | CALC | FIX. StallMD is low in DONE, so the instruction advances into E/M together with WriteLoHiE at edge 34.
- StartE in CALC, FIX or DONE is ignored. The stalled instruction itself is still asserting StartE during DONE and must not retrigger.
- The earliest back-to-back start is cycle 35.
- KillE:
  - In CALC or FIX: the next edge goes to IDLE. No WriteLoHiE is issued; StallMD is low in the following cycle.
  - In DONE: WriteLoHiE is forced to 0 combinationally.
- RESET mid-operation: abandon the operation with no write. Require a fresh StartE afterwards.
- loHi_dataE and DivZeroE hold 0 outside DONE.

Decomposition:
- Shared package (muldiv_pkg):
  - op codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encoding IDLE/CALC/FIX/DONE;
  - constant MD_ITERS=DATA_W.
- Sub-module muldiv_step: combinational single iteration (shift-add or compare-subtract) selected by the op type. It is instantiated once inside the sequencer.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF, StartE at cycle 0 -> StallMD high cycles 0..33; cycle 34 WriteLoHiE=1, loHi_dataE=0xFFFFFFFE_00000001.
- MULT 0xFFFFFFFD×0x00000007 -> cycle 34 loHi_dataE=0xFFFFFFFF_FFFFFFEB, DivZeroE=0.
- DIV 0xFFFFFFF9÷0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 0x00000064÷0x00000007 -> Lo=0x0000000E, Hi=0x00000002.
- DIVU 0x00000064÷0 -> cycle 34 Lo=0xFFFFFFFF, Hi=0x00000064, DivZeroE=1.
- MULT started, KillE=1 at cycle 10 -> StallMD=0 and BusyMD=0 from cycle 11; WriteLoHiE never asserts. StartE held high through DONE -> exactly one WriteLoHiE pulse.
- RESET pulsed asynchronously mid-CALC (cycle 20) -> all outputs 0 without waiting for CLK. A new MULTU 3×5 afterwards -> loHi_dataE=0x00000000_0000000F 34 cycles after its start.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation codes as presented on OpE, the sequencer state encoding and
// the iteration count of the shift-add / restoring-divide loop.
package muldiv_pkg;

  localparam int MD_ITERS = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide loop.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : upper half (product high / partial remainder)
//   lo_i     : lower half (multiplier being consumed / quotient being built)
//   mcand_i  : multiplicand or divisor magnitude
//   acc_o, lo_o : the pair after this iteration
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic [DATA_W-1:0] mcand_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   psum;
  logic [DATA_W:0]   rsh;
  logic [DATA_W-1:0] diff;
  logic              ge;

  always_comb begin
    // Multiply: the carry out of the add shifts into the top of acc.
    sum  = {1'b0, acc_i} + {1'b0, mcand_i};
    psum = lo_i[0] ? sum : {1'b0, acc_i};
    // Divide: remainder is kept below the divisor, so the shifted value
    // needs one extra bit but the difference always fits in DATA_W.
    rsh  = {acc_i, lo_i[DATA_W-1]};
    ge   = (rsh >= {1'b0, mcand_i});
    diff = rsh[DATA_W-1:0] - mcand_i;

    if (is_div_i) begin
      acc_o = ge ? diff : rsh[DATA_W-1:0];
      lo_o  = {lo_i[DATA_W-2:0], ge};
    end else begin
      acc_o = psum[DATA_W:1];
      lo_o  = {psum[0], lo_i[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the Execute stage.
//   CLK, RESET          : clock, asynchronous active-high reset
//   StartE, OpE         : mult/div instruction present in E and its opcode
//   SrcAE, SrcBE        : rs / rt operands
//   KillE               : flush of the E-stage instruction
//   StallMD             : hold PC, F/D and D/E while computing
//   WriteLoHiE          : Lo/Hi write enable carried down the pipe
//   loHi_dataE          : {Hi, Lo} result, zero outside the DONE cycle
//   DivZeroE            : divide-by-zero flag, qualified by WriteLoHiE
//   BusyMD              : sequencer not idle
// Signed operations run on magnitudes; the sign is restored in FIX.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MD_ITERS
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                StartE,
  input  logic [1:0]          OpE,
  input  logic [DATA_W-1:0]   SrcAE,
  input  logic [DATA_W-1:0]   SrcBE,
  input  logic                KillE,
  output logic                StallMD,
  output logic                WriteLoHiE,
  output logic [2*DATA_W-1:0] loHi_dataE,
  output logic                DivZeroE,
  output logic                BusyMD
);

  localparam int CW = $clog2(DATA_W);

  md_state_e           state_q, state_d;
  md_op_e              op_q, op_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
  logic [DATA_W-1:0]   acc_q, acc_d, lo_q, lo_d, mcand_q, mcand_d;
  logic [2*DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0]   step_acc, step_lo;
  logic                is_div, start, sgn;

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] x);
    return (~x) + DATA_W'(1);
  endfunction

  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] x);
    return (~x) + (2*DATA_W)'(1);
  endfunction

  assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign start  = ~RESET && (state_q == IDLE) && StartE && ~KillE;
  assign sgn    = ~OpE[0];

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div_i (is_div),
    .acc_i    (acc_q),
    .lo_i     (lo_q),
    .mcand_i  (mcand_q),
    .acc_o    (step_acc),
    .lo_o     (step_lo)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Multiply and divide load identically: acc=0, lo=|A|, mcand=|B|.
          op_d    = md_op_e'(OpE);
          sa_d    = sgn & SrcAE[DATA_W-1];
          sb_d    = sgn & SrcBE[DATA_W-1];
          dz_d    = OpE[1] & (SrcBE == '0);
          acc_d   = '0;
          lo_d    = (sgn & SrcAE[DATA_W-1]) ? neg_w(SrcAE) : SrcAE;
          mcand_d = (sgn & SrcBE[DATA_W-1]) ? neg_w(SrcBE) : SrcBE;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (KillE) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          lo_d  = step_lo;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_W - 1)) state_d = FIX;
        end
      end
      FIX: begin
        if (KillE) begin
          state_d = IDLE;
        end else begin
          // With a zero divisor the loop leaves quotient all-ones and the
          // remainder equal to |A|; skipping only the quotient negation
          // makes Hi the raw dividend.
          if (is_div)
            res_d = {(sa_q ? neg_w(acc_q) : acc_q),
                     ((sa_q ^ sb_q) & ~dz_q) ? neg_w(lo_q) : lo_q};
          else
            res_d = (sa_q ^ sb_q) ? neg_2w({acc_q, lo_q}) : {acc_q, lo_q};
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      res_q   <= res_d;
    end
  end

  assign BusyMD     = (state_q != IDLE);
  assign StallMD    = start || (state_q == CALC) || (state_q == FIX);
  assign WriteLoHiE = (state_q == DONE) && ~KillE;
  assign loHi_dataE = (state_q == DONE) ? res_q : '0;
  assign DivZeroE   = WriteLoHiE & dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  logic        CLK, RESET, StartE, KillE;
  logic [1:0]  OpE;
  logic [31:0] SrcAE, SrcBE;
  logic        StallMD, WriteLoHiE, DivZeroE, BusyMD;
  logic [63:0] loHi_dataE;

  int checks = 0;
  int failures = 0;

  muldiv_seq #(.DATA_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .StartE(StartE), .OpE(OpE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .KillE(KillE),
    .StallMD(StallMD), .WriteLoHiE(WriteLoHiE), .loHi_dataE(loHi_dataE),
    .DivZeroE(DivZeroE), .BusyMD(BusyMD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    logic        dz;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: the architectural result from plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; return p; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; return u; end
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Called just after an edge; that cycle is cycle 0. StartE is held until
  // the end of cycle 34, like a stalled instruction would.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int kill_at, output logic [63:0] data, output logic dz,
                        output int wcyc, output int nwr, output int nstall);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b;
    data = '0; dz = 1'b0; wcyc = -1; nwr = 0; nstall = 0;
    for (int c = 0; c < 45; c++) begin
      KillE = (c == kill_at);
      @(negedge CLK);
      if (StallMD) nstall++;
      if (WriteLoHiE) begin
        nwr++;
        if (wcyc < 0) begin wcyc = c; data = loHi_dataE; dz = DivZeroE; end
      end
      @(posedge CLK); #1;
      KillE = 1'b0;
      if (c >= 34) StartE = 1'b0;
    end
  endtask

  vec_t vecs[8];
  logic [63:0] d;
  logic        z;
  int          wc, nw, ns;
  logic [1:0]  rop;
  logic [31:0] ra, rb;
  int          seen;

  initial begin
    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[3] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_0064, 32'h0000_0000, 64'h0000_0064_FFFF_FFFF, 1'b1};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0};
    vecs[6] = '{2'b10, 32'hFFFF_FF00, 32'h0000_0000, 64'hFFFF_FF00_FFFF_FFFF, 1'b1};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};

    RESET = 1'b1; StartE = 1'b1; KillE = 1'b0; OpE = 2'b00; SrcAE = 32'd5; SrcBE = 32'd3;
    @(negedge CLK);
    chk("rst_stall", {63'b0, StallMD}, 64'd0);
    chk("rst_busy", {63'b0, BusyMD}, 64'd0);
    chk("rst_outs", {61'b0, WriteLoHiE, DivZeroE, |loHi_dataE}, 64'd0);
    @(posedge CLK); #1;
    StartE = 1'b0; RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_busy", {62'b0, BusyMD, StallMD}, 64'd0);
    chk("post_rst_data", loHi_dataE, 64'd0);
    @(posedge CLK); #1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, d, z, wc, nw, ns);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
      chk($sformatf("vec%0d_dz", i), {63'b0, z}, {63'b0, vecs[i].dz});
      chk($sformatf("vec%0d_wcyc", i), 64'(wc), 64'd34);
      chk($sformatf("vec%0d_nwr", i), 64'(nw), 64'd1);
      chk($sformatf("vec%0d_stall", i), 64'(ns), 64'd34);
      @(negedge CLK);
      chk($sformatf("vec%0d_idle_out", i), {loHi_dataE[62:0], DivZeroE | BusyMD | loHi_dataE[63]}, 64'd0);
      @(posedge CLK); #1;
    end

    // Kill in CALC at cycle 10: the flushed instruction also drops StartE.
    StartE = 1'b1; OpE = 2'b00; SrcAE = 32'd9; SrcBE = 32'd9;
    for (int c = 0; c < 10; c++) begin @(posedge CLK); #1; end
    KillE = 1'b1; StartE = 1'b0;
    @(posedge CLK); #1;
    KillE = 1'b0;
    @(negedge CLK);
    chk("kill_calc_stall", {63'b0, StallMD}, 64'd0);
    chk("kill_calc_busy", {63'b0, BusyMD}, 64'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (WriteLoHiE) seen++;
    end
    chk("kill_calc_nowrite", 64'(seen), 64'd0);
    @(posedge CLK); #1;

    // Kill in DONE suppresses the write.
    run_op(2'b01, 32'd6, 32'd7, 34, d, z, wc, nw, ns);
    chk("kill_done_nwr", 64'(nw), 64'd0);

    // Asynchronous reset mid-CALC, then a fresh operation.
    StartE = 1'b1; OpE = 2'b01; SrcAE = 32'h1234_5678; SrcBE = 32'h9ABC_DEF0;
    for (int c = 0; c < 20; c++) begin @(posedge CLK); #1; end
    #2 RESET = 1'b1;
    #1;
    chk("async_rst_busy", {63'b0, BusyMD}, 64'd0);
    chk("async_rst_outs", {61'b0, StallMD, WriteLoHiE, DivZeroE}, 64'd0);
    chk("async_rst_data", loHi_dataE, 64'd0);
    StartE = 1'b0;
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("after_rst_busy", {63'b0, BusyMD}, 64'd0);
    @(posedge CLK); #1;
    run_op(2'b01, 32'd3, 32'd5, -1, d, z, wc, nw, ns);
    chk("post_rst_mul_data", d, 64'h0000_0000_0000_000F);
    chk("post_rst_mul_wcyc", 64'(wc), 64'd34);

    // Randomised operations against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
      run_op(rop, ra, rb, -1, d, z, wc, nw, ns);
      chk($sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb), d, ref_md(rop, ra, rb));
      chk($sformatf("rnd%0d_dz", i), {63'b0, z}, {63'b0, (rop[1] && rb == 0)});
      chk($sformatf("rnd%0d_wcyc", i), 64'(wc), 64'd34);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
